// File: rtl/hough_accumulator.sv
// Hough vote accumulator: bins (rho, theta) votes into a RAM, then scans it for the strongest line and clears it.
// Latency: a vote reaches RAM 3 cycles after acceptance; the peak is reported RHO_BINS*THETA_STEPS+~3 cycles after frame_done.
// Backpressure: vote_ready is low outside ACCUM; votes offered then (or out of range) are dropped and counted.
//
// Ports: clock/reset (sync, active-low); vote_valid/vote_rho/vote_theta vote stream; frame_done end-of-frame pulse;
//        vote_ready/busy status; peak_valid/peak_rho/peak_theta/peak_count strongest bin; drop_count discarded votes.
module hough_accumulator #(
    parameter int RHO_W       = 11,
    parameter int THETA_W     = 8,
    parameter int RHO_OFFSET  = 800,
    parameter int RHO_BINS    = 1601,
    parameter int THETA_STEPS = 180,
    parameter int ACC_W       = 8,
    parameter int ADDR_W      = 19
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vote_valid,
    input  logic [RHO_W-1:0]   vote_rho,
    input  logic [THETA_W-1:0] vote_theta,
    input  logic               frame_done,
    output logic               vote_ready,
    output logic               busy,
    output logic               peak_valid,
    output logic [RHO_W-1:0]   peak_rho,
    output logic [THETA_W-1:0] peak_theta,
    output logic [ACC_W-1:0]   peak_count,
    output logic [15:0]        drop_count
);

    localparam int                N_BINS        = RHO_BINS * THETA_STEPS;
    localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(N_BINS - 1);
    localparam logic [RHO_W:0]    RHO_BINS_L    = (RHO_W+1)'(RHO_BINS);
    localparam logic [THETA_W:0]  THETA_STEPS_L = (THETA_W+1)'(THETA_STEPS);
    localparam logic [RHO_W-1:0]  RHO_LAST      = RHO_W'(RHO_BINS - 1);

    typedef enum logic [1:0] {ST_INIT, ST_ACCUM, ST_DRAIN, ST_SCAN} state_t;

    logic [ACC_W-1:0] mem [N_BINS];
    logic [ACC_W-1:0] rd_dat_q;

    state_t             state_q, state_d;
    logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, wb_vld_q, wb_vld_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d, wb_addr_q, wb_addr_d;
    logic [ACC_W-1:0]   wb_dat_q, wb_dat_d;
    logic [ADDR_W-1:0]  scan_addr_q, scan_addr_d;
    logic               scan_run_q, scan_run_d;
    logic [RHO_W-1:0]   rho_cnt_q, rho_cnt_d, sc1_rho_q, sc1_rho_d, max_rho_q, max_rho_d;
    logic [THETA_W-1:0] theta_cnt_q, theta_cnt_d, sc1_theta_q, sc1_theta_d, max_theta_q, max_theta_d;
    logic               sc1_vld_q, sc1_vld_d, sc1_last_q, sc1_last_d;
    logic [ACC_W-1:0]   max_cnt_q, max_cnt_d;
    logic               peak_valid_q, peak_valid_d;
    logic [RHO_W-1:0]   peak_rho_q, peak_rho_d;
    logic [THETA_W-1:0] peak_theta_q, peak_theta_d;
    logic [ACC_W-1:0]   peak_count_q, peak_count_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic               vote_ready_q, vote_ready_d, busy_q, busy_d;

    logic [RHO_W:0]     idx;
    logic               in_range;
    logic [ADDR_W-1:0]  vote_addr;
    logic [ACC_W-1:0]   old_cnt, new_cnt;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr, mem_raddr;
    logic [ACC_W-1:0]   mem_wdat;

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        scan_run_d   = scan_run_q;
        rho_cnt_d    = rho_cnt_q;
        theta_cnt_d  = theta_cnt_q;
        sc1_vld_d    = 1'b0;
        sc1_last_d   = 1'b0;
        sc1_rho_d    = sc1_rho_q;
        sc1_theta_d  = sc1_theta_q;
        max_cnt_d    = max_cnt_q;
        max_rho_d    = max_rho_q;
        max_theta_d  = max_theta_q;
        peak_valid_d = 1'b0;
        peak_rho_d   = peak_rho_q;
        peak_theta_d = peak_theta_q;
        peak_count_d = peak_count_q;
        drop_count_d = drop_count_q;

        // S0: bin index in RHO_W+1 bits so the sign bit flags negative indices.
        idx       = {vote_rho[RHO_W-1], vote_rho} + (RHO_W+1)'(RHO_OFFSET);
        in_range  = !idx[RHO_W] && (idx < RHO_BINS_L) && ({1'b0, vote_theta} < THETA_STEPS_L);
        vote_addr = ADDR_W'(vote_theta) * ADDR_W'(RHO_BINS) + ADDR_W'(idx[RHO_W-1:0]);

        if (vote_valid && !(vote_ready_q && in_range) && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;

        s1_vld_d  = vote_valid && vote_ready_q && in_range;
        s1_addr_d = vote_addr;
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;

        // The RAM read for a vote one behind the same bin sees the pre-write value;
        // substitute the write issued on the previous cycle.
        old_cnt = (wb_vld_q && wb_addr_q == s2_addr_q) ? wb_dat_q : rd_dat_q;
        new_cnt = (old_cnt == {ACC_W{1'b1}}) ? old_cnt : old_cnt + 1'b1;
        wb_vld_d  = s2_vld_q;
        wb_addr_d = s2_addr_q;
        wb_dat_d  = new_cnt;

        mem_we    = s2_vld_q;
        mem_waddr = s2_addr_q;
        mem_wdat  = new_cnt;
        mem_raddr = s1_addr_q;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = scan_addr_q;
                mem_wdat  = '0;
                if (scan_addr_q == ADDR_LAST) begin
                    state_d     = ST_ACCUM;
                    scan_addr_d = '0;
                end else begin
                    scan_addr_d = scan_addr_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                if (frame_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d     = ST_SCAN;
                    scan_addr_d = '0;
                    scan_run_d  = 1'b1;
                    rho_cnt_d   = '0;
                    theta_cnt_d = '0;
                    max_cnt_d   = '0;
                    max_rho_d   = '0;
                    max_theta_d = '0;
                end
            end
            ST_SCAN: begin
                // Read-and-clear each bin; rho/theta counters track the address so no divider is needed.
                if (scan_run_q) begin
                    mem_raddr   = scan_addr_q;
                    mem_we      = 1'b1;
                    mem_waddr   = scan_addr_q;
                    mem_wdat    = '0;
                    sc1_vld_d   = 1'b1;
                    sc1_last_d  = (scan_addr_q == ADDR_LAST);
                    sc1_rho_d   = rho_cnt_q;
                    sc1_theta_d = theta_cnt_q;
                    if (scan_addr_q == ADDR_LAST) begin
                        scan_run_d = 1'b0;
                    end else begin
                        scan_addr_d = scan_addr_q + 1'b1;
                        if (rho_cnt_q == RHO_LAST) begin
                            rho_cnt_d   = '0;
                            theta_cnt_d = theta_cnt_q + 1'b1;
                        end else begin
                            rho_cnt_d = rho_cnt_q + 1'b1;
                        end
                    end
                end
                // Strict > keeps the lowest address on ties.
                if (sc1_vld_q && rd_dat_q > max_cnt_q) begin
                    max_cnt_d   = rd_dat_q;
                    max_rho_d   = sc1_rho_q;
                    max_theta_d = sc1_theta_q;
                end
                if (sc1_vld_q && sc1_last_q) begin
                    peak_valid_d = 1'b1;
                    peak_rho_d   = max_rho_d - RHO_W'(RHO_OFFSET);
                    peak_theta_d = max_theta_d;
                    peak_count_d = max_cnt_d;
                    state_d      = ST_ACCUM;
                end
            end
            default: state_d = ST_INIT;
        endcase

        vote_ready_d = (state_d == ST_ACCUM);
        busy_d       = !vote_ready_d;
    end

    always_ff @(posedge clock) begin
        if (mem_we && reset) mem[mem_waddr] <= mem_wdat;
        rd_dat_q <= mem[mem_raddr];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            s1_vld_q     <= 1'b0;
            s1_addr_q    <= '0;
            s2_vld_q     <= 1'b0;
            s2_addr_q    <= '0;
            wb_vld_q     <= 1'b0;
            wb_addr_q    <= '0;
            wb_dat_q     <= '0;
            scan_addr_q  <= '0;
            scan_run_q   <= 1'b0;
            rho_cnt_q    <= '0;
            theta_cnt_q  <= '0;
            sc1_vld_q    <= 1'b0;
            sc1_last_q   <= 1'b0;
            sc1_rho_q    <= '0;
            sc1_theta_q  <= '0;
            max_cnt_q    <= '0;
            max_rho_q    <= '0;
            max_theta_q  <= '0;
            peak_valid_q <= 1'b0;
            peak_rho_q   <= '0;
            peak_theta_q <= '0;
            peak_count_q <= '0;
            drop_count_q <= '0;
            vote_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            s1_vld_q     <= s1_vld_d;
            s1_addr_q    <= s1_addr_d;
            s2_vld_q     <= s2_vld_d;
            s2_addr_q    <= s2_addr_d;
            wb_vld_q     <= wb_vld_d;
            wb_addr_q    <= wb_addr_d;
            wb_dat_q     <= wb_dat_d;
            scan_addr_q  <= scan_addr_d;
            scan_run_q   <= scan_run_d;
            rho_cnt_q    <= rho_cnt_d;
            theta_cnt_q  <= theta_cnt_d;
            sc1_vld_q    <= sc1_vld_d;
            sc1_last_q   <= sc1_last_d;
            sc1_rho_q    <= sc1_rho_d;
            sc1_theta_q  <= sc1_theta_d;
            max_cnt_q    <= max_cnt_d;
            max_rho_q    <= max_rho_d;
            max_theta_q  <= max_theta_d;
            peak_valid_q <= peak_valid_d;
            peak_rho_q   <= peak_rho_d;
            peak_theta_q <= peak_theta_d;
            peak_count_q <= peak_count_d;
            drop_count_q <= drop_count_d;
            vote_ready_q <= vote_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign vote_ready = vote_ready_q;
    assign busy       = busy_q;
    assign peak_valid = peak_valid_q;
    assign peak_rho   = peak_rho_q;
    assign peak_theta = peak_theta_q;
    assign peak_count = peak_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_hough_accumulator.sv
// Bench for hough_accumulator in a small 8 rho x 4 theta configuration (offset 4).
// Expected peaks are queued by the stimulus and checked by a monitor on every peak_valid pulse.
// Status outputs (reset state, INIT length, drop_count) are checked directly.
module tb_hough_accumulator;

    localparam int RW = 4;
    localparam int TW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vote_valid = 1'b0;
    logic [RW-1:0] vote_rho = '0;
    logic [TW-1:0] vote_theta = '0;
    logic          frame_done = 1'b0;
    logic          vote_ready, busy, peak_valid;
    logic [RW-1:0] peak_rho;
    logic [TW-1:0] peak_theta;
    logic [7:0]    peak_count;
    logic [15:0]   drop_count;

    hough_accumulator #(
        .RHO_W(RW), .THETA_W(TW), .RHO_OFFSET(4), .RHO_BINS(8),
        .THETA_STEPS(4), .ACC_W(8), .ADDR_W(5)
    ) dut (
        .clock(clock), .reset(reset), .vote_valid(vote_valid), .vote_rho(vote_rho),
        .vote_theta(vote_theta), .frame_done(frame_done), .vote_ready(vote_ready),
        .busy(busy), .peak_valid(peak_valid), .peak_rho(peak_rho), .peak_theta(peak_theta),
        .peak_count(peak_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int rho;
        int theta;
        int cnt;
    } pk_t;

    pk_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  pk_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_peak(input int r, input int t, input int c);
        pk_t e;
        e.rho = r; e.theta = t; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every peak_valid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (peak_valid) begin
            pk_t e;
            pk_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_peak", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("peak_rho", int'($signed(peak_rho)), e.rho);
                chk("peak_theta", int'(peak_theta), e.theta);
                chk("peak_count", int'(peak_count), e.cnt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic vote1(input int r, input int t);
        vote_valid = 1'b1;
        vote_rho   = r[RW-1:0];
        vote_theta = t[TW-1:0];
        @(negedge clock);
        vote_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    // Ends a frame; optionally with a (rho 0, theta 0) vote on the frame_done cycle,
    // and optionally with a vote offered while the scan is running.
    task automatic frame_end(input bit vote_same, input bit scan_vote);
        frame_done = 1'b1;
        if (vote_same) begin
            vote_valid = 1'b1;
            vote_rho   = '0;
            vote_theta = '0;
        end
        @(negedge clock);
        frame_done = 1'b0;
        vote_valid = 1'b0;
        if (scan_vote) begin
            idle(6);
            vote1(0, 0);
        end
        wait_ready("frame_completes");
        idle(2);
        chk("peak_consumed", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int prev;

        // Reset state
        idle(2);
        chk("rst_vote_ready", int'(vote_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_peak_valid", int'(peak_valid), 0);
        chk("rst_peak_rho", int'(peak_rho), 0);
        chk("rst_peak_theta", int'(peak_theta), 0);
        chk("rst_peak_count", int'(peak_count), 0);
        chk("rst_drop_count", int'(drop_count), 0);

        // INIT clears 32 bins, one per cycle
        reset = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("init_cycles", n, 32);
        chk("ready_after_init", int'(vote_ready), 1);
        chk("peak_count_after_init", int'(peak_count), 0);

        // Spaced votes: (1,2) x3 and (-2,0) x1
        vote1(1, 2); idle(2);
        vote1(1, 2); idle(2);
        vote1(1, 2); idle(1);
        vote1(-2, 0);
        expect_peak(1, 2, 3);
        frame_end(1'b0, 1'b0);
        chk("drop_after_valid_votes", int'(drop_count), 0);

        // Empty frame: previous frame's bins must have been cleared by the scan
        expect_peak(-4, 0, 0);
        frame_end(1'b0, 1'b0);

        // 300 back-to-back votes to one bin saturate at 255
        for (int i = 0; i < 300; i++) vote1(0, 1);
        expect_peak(0, 1, 255);
        frame_end(1'b0, 1'b0);

        // Alternating bins A=(2,3) addr 30 and B=(-3,1) addr 9; tie goes to lower address
        for (int i = 0; i < 5; i++) begin
            vote1(2, 3);
            vote1(-3, 1);
        end
        expect_peak(-3, 1, 5);
        frame_end(1'b0, 1'b0);

        // Out-of-range votes are dropped and never reach RAM
        vote1(4, 0);
        vote1(-5, 0);
        vote1(0, 4);
        idle(3);
        chk("drop_out_of_range", int'(drop_count), 3);
        expect_peak(-4, 0, 0);
        frame_end(1'b0, 1'b1);
        chk("drop_during_scan", int'(drop_count), 4);

        // A vote on the frame_done cycle is still counted
        expect_peak(0, 0, 1);
        frame_end(1'b1, 1'b0);

        // Reset during SCAN aborts without a peak; counts restart from zero
        vote1(1, 1);
        vote1(1, 1);
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
        idle(10);
        prev  = pk_seen;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_drop_cleared", int'(drop_count), 0);
        chk("abort_busy", int'(busy), 1);
        reset = 1'b1;
        wait_ready("reinit_completes");
        idle(3);
        chk("no_peak_on_abort", pk_seen, prev);
        vote1(1, 1);
        expect_peak(1, 1, 1);
        frame_end(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
